// File: rtl/aa_pkg.sv
// Shared types for the anti-aliasing frame sequencer: FSM states,
// window slot indices and the default pixel width.
package aa_pkg;

  localparam int AA_PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    DONE
  } aa_state_e;

  // Read order within a pixel's window: centre first, then N, S, W, E.
  typedef enum logic [2:0] {
    NB_C,
    NB_N,
    NB_S,
    NB_W,
    NB_E
  } aa_nbr_e;

endpackage

// File: rtl/aa_kernel.sv
// Anti-aliasing kernel: purely combinational. An interior pixel brighter
// than the threshold with at least one darker neighbour is replaced by the
// floor of its four-neighbour mean; every other pixel passes through.
module aa_kernel
  import aa_pkg::*;
#(
  parameter int PIX_W = AA_PIX_W
) (
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] n,
  input  logic [PIX_W-1:0] s,
  input  logic [PIX_W-1:0] w,
  input  logic [PIX_W-1:0] e,
  input  logic [PIX_W-1:0] th,
  input  logic             is_border,
  output logic [PIX_W-1:0] out_pix,
  output logic             modified
);

  // Four-pixel mean; the sum carries two guard bits and the shift floors.
  function automatic logic [PIX_W-1:0] avg4(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] cc,
                                            input logic [PIX_W-1:0] d);
    logic [PIX_W+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, cc} + {2'b00, d};
    return sum[PIX_W+1:2];
  endfunction

  // Strict unsigned compares: a value equal to th never triggers.
  always_comb begin
    modified = !is_border && (c > th) &&
               ((n < th) || (s < th) || (w < th) || (e < th));
    out_pix  = modified ? avg4(n, s, w, e) : c;
  end

endmodule

// File: rtl/aa_frame_sequencer.sv
// Frame sequencer for the anti-aliasing filter. Walks the frame in raster
// order, reads each pixel's cross window (centre only on the border), runs
// it through aa_kernel and writes the result under a valid/ready handshake.
// Optional build macro AA_STATS_EN adds the edge_cnt port and counter.
module aa_frame_sequencer
  import aa_pkg::*;
#(
  parameter  int WIDTH  = 64,
  parameter  int HEIGHT = 64,
  parameter  int PIX_W  = AA_PIX_W,
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  th,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  input  logic              wr_ready
`ifdef AA_STATS_EN
  ,
  output logic [ADDR_W:0]   edge_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(HEIGHT - 1);

  aa_state_e         state_q, state_d;
  aa_nbr_e           nidx_q, nidx_d;
  aa_nbr_e           cap_idx_q, cap_idx_d;
  logic              cap_vld_q, cap_vld_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [PIX_W-1:0]  th_q, th_d;
  logic [PIX_W-1:0]  win_c_q, win_c_d;
  logic [PIX_W-1:0]  win_n_q, win_n_d;
  logic [PIX_W-1:0]  win_s_q, win_s_d;
  logic [PIX_W-1:0]  win_w_q, win_w_d;
  logic [PIX_W-1:0]  win_e_q, win_e_d;

  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] nbr_addr;
  logic              is_border;
  logic              is_last;
  logic [PIX_W-1:0]  k_out;
  logic              k_mod;

  // Current pixel position, border/last flags and the address of the
  // window slot being read this cycle. Neighbour reads only happen for
  // interior pixels, so the +/- offsets never wrap.
  always_comb begin
    addr_c    = row_q * WIDTH_A + col_q;
    is_border = (row_q == '0) || (row_q == ROW_LAST) ||
                (col_q == '0) || (col_q == COL_LAST);
    is_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    case (nidx_q)
      NB_N:    nbr_addr = addr_c - WIDTH_A;
      NB_S:    nbr_addr = addr_c + WIDTH_A;
      NB_W:    nbr_addr = addr_c - ONE_A;
      NB_E:    nbr_addr = addr_c + ONE_A;
      default: nbr_addr = addr_c;
    endcase
  end

  aa_kernel #(
    .PIX_W(PIX_W)
  ) u_kernel (
    .c        (win_c_q),
    .n        (win_n_q),
    .s        (win_s_q),
    .w        (win_w_q),
    .e        (win_e_q),
    .th       (th_q),
    .is_border(is_border),
    .out_pix  (k_out),
    .modified (k_mod)
  );

  // Next-state and output logic; outputs are low outside their states.
  always_comb begin
    state_d   = state_q;
    nidx_d    = nidx_q;
    row_d     = row_q;
    col_d     = col_q;
    th_d      = th_q;
    cap_vld_d = 1'b0;
    cap_idx_d = nidx_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          th_d    = th;
          row_d   = '0;
          col_d   = '0;
          nidx_d  = NB_C;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = nbr_addr;
        cap_vld_d = 1'b1;
        if (is_border || (nidx_q == NB_E)) begin
          state_d = WAIT;
        end else begin
          nidx_d = aa_nbr_e'(nidx_q + 3'd1);
        end
      end
      WAIT: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = addr_c;
        wr_data  = k_out;
        if (wr_ready) begin
          nidx_d = NB_C;
          if (is_last) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + ONE_A;
            end else begin
              col_d = col_q + ONE_A;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window slot update: read data lands one cycle after its strobe, into
  // the slot that was being addressed on that strobe.
  always_comb begin
    win_c_d = win_c_q;
    win_n_d = win_n_q;
    win_s_d = win_s_q;
    win_w_d = win_w_q;
    win_e_d = win_e_q;
    if (cap_vld_q) begin
      case (cap_idx_q)
        NB_C:    win_c_d = rd_data;
        NB_N:    win_n_d = rd_data;
        NB_S:    win_s_d = rd_data;
        NB_W:    win_w_d = rd_data;
        NB_E:    win_e_d = rd_data;
        default: win_c_d = win_c_q;
      endcase
    end
  end

  // Control registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      nidx_q    <= NB_C;
      cap_vld_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      nidx_q    <= nidx_d;
      cap_vld_q <= cap_vld_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  // Data registers: threshold and the five-pixel window.
  always_ff @(posedge clk) begin
    cap_idx_q <= cap_idx_d;
    th_q      <= th_d;
    win_c_q   <= win_c_d;
    win_n_q   <= win_n_d;
    win_s_q   <= win_s_d;
    win_w_q   <= win_w_d;
    win_e_q   <= win_e_d;
  end

`ifdef AA_STATS_EN
  logic [ADDR_W:0] edge_cnt_q, edge_cnt_d;

  // Modified-pixel count: cleared on start, bumped on each accepted
  // write whose pixel met the kernel condition, held after done.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if ((state_q == IDLE) && start) begin
      edge_cnt_d = '0;
    end else if ((state_q == WRITE) && wr_ready && k_mod) begin
      edge_cnt_d = edge_cnt_q + (ADDR_W + 1)'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = k_mod;
`endif

endmodule

// File: doc/aa_frame_sequencer.md
# aa_frame_sequencer

Frame-level controller for the anti-aliasing filter. It walks a stored frame in raster order and fetches each pixel plus its four cross neighbours from the frame memory. The fetched window goes through the anti-aliasing kernel, and the sequencer writes the result to the output frame memory under a valid/ready handshake. Software starts it with a start pulse and receives a done pulse when the whole frame has been written.

## Interface
- `WIDTH`, 64, frame columns (≥3)
- `HEIGHT`, 64, frame rows (≥3)
- `PIX_W`, 8, pixel width
- `ADDR_W`, `$clog2(WIDTH*HEIGHT)`, localparam, memory address width
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to process a frame; ignored unless idle
- `th`  in  PIX_W  edge threshold, sampled when `start` is accepted
- `busy`  out  1  high from the cycle after start acceptance through the final write
- `done`  out  1  one-cycle pulse after the final write is accepted
- `rd_en`  out  1  frame memory read strobe
- `rd_addr`  out  ADDR_W  read address = row*WIDTH+col
- `rd_data`  in  PIX_W  read data; valid exactly 1 cycle after `rd_en`
- `wr_valid`  out  1  output pixel valid
- `wr_addr`  out  ADDR_W  output address, same mapping as `rd_addr`
- `wr_data`  out  PIX_W  filtered pixel
- `wr_ready`  in  1  output memory accepts when high together with `wr_valid`
- `edge_cnt`  out  ADDR_W+1  modified-pixel count (only with `AA_STATS_EN`)

## Operation
- FSM states: IDLE, FETCH, WAIT, WRITE, DONE.
- **IDLE**
  - On `start`: latch `th`, clear row/col and the neighbour index, then go to FETCH.
- **FETCH**
  - Issue one read per cycle in the order C, N, S, W, E.
  - Neighbour addresses: N = (row−1,col), S = (row+1,col), W = (row,col−1), E = (row,col+1).
  - Border pixels (row 0 or HEIGHT−1, col 0 or WIDTH−1) issue only the C read.
- **WAIT**
  - One cycle that captures the last read's data.
  - Each `rd_data` is registered into its window slot one cycle after its `rd_en`.
- **WRITE**
  - Hold `wr_valid`, `wr_addr` and `wr_data` stable until `wr_ready`.
  - On acceptance: if this was the last pixel, go to DONE; otherwise advance col (wrapping to 0 and incrementing row at WIDTH−1) and go to FETCH.
- **DONE**
  - Pulse `done` for one cycle, then return to IDLE.
- **Kernel rule** (interior pixels)
  - If C > th and any neighbour < th: out = (N+S+W+E) >> 2.
  - The neighbour sum is PIX_W+2 bits and truncation is downward.
  - Otherwise out = C.
  - Comparisons are unsigned and strict; equality with th does not trigger.
- **Border pixels**: out = C unchanged.
- `start` while not IDLE is ignored; `th` is not re-sampled.
- `reset` at any point:
  - forces IDLE and clears all counters;
  - drives all outputs low, including `edge_cnt` = 0;
  - abandons the in-flight write.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: first FETCH; `busy` = 1.
- Border pixel: 3 cycles (FETCH, WAIT, WRITE) with `wr_ready` = 1.
- Interior pixel: 7 cycles (5 FETCH, WAIT, WRITE).
- Each cycle of `wr_ready` = 0 adds one cycle; reads never proceed while a write is pending.
- Frame latency with ready held high: 3·B + 7·I cycles to the final write, where B = 2·WIDTH + 2·HEIGHT − 4 and I = (WIDTH−2)(HEIGHT−2).
- `done` is asserted the cycle after the final accepted write, and `busy` drops in the same cycle.
- `rd_en` and `wr_valid` are never high in the same cycle.

## Configuration
- `AA_STATS_EN` defined:
  - `edge_cnt` port exists.
  - It is cleared on start acceptance and incremented on each accepted write whose pixel met the kernel condition.
  - It holds its value after `done` until the next start.
- `AA_STATS_EN` undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- **`aa_pkg`**:
  - state enum (IDLE/FETCH/WAIT/WRITE/DONE);
  - neighbour index enum (C/N/S/W/E);
  - default `PIX_W` constant.
- **`aa_kernel`**:
  - a single combinational sub-module;
  - inputs: five pixels, th, and an is_border flag;
  - outputs: out pixel and a modified flag.
  - It is the reusable datapath the sequencer drives.

## Test plan
- WIDTH = HEIGHT = 4, all pixels 10, th = 5, `wr_ready` = 1 → 16 writes equal to the input, final write at cycle 64, `done` at cycle 65, `edge_cnt` = 0.
- Interior (1,1): C = 200, N/S/W = 100, E = 104, th = 150 → `wr_data` = 101 at address 5, `edge_cnt` = 1.
- C = 150, one neighbour = 150, th = 150 → output 150 unchanged (strict compares).
- `wr_ready` held low for 5 cycles on pixel 0 → `wr_valid`, `wr_addr` and `wr_data` stable, no `rd_en`, frame completes 5 cycles late.
- `start` re-pulsed mid-frame with a different th → ignored; results use the original th.
- `reset` asserted during FETCH of pixel 6 → next cycle all outputs 0 and the FSM is in IDLE; a fresh `start` reprocesses from address 0.
